// File: rtl/counter_pkg.sv
// Shared encodings for the interval-counter control stage and the counter itself:
// FSM state codes, register word addresses and CTRL/STATUS bit positions.
package counter_pkg;

    typedef enum logic [7:0] {
        ST_RESET = 8'd0,
        ST_RUN   = 8'd1,
        ST_HALT  = 8'd2
    } cnt_state_e;

    localparam logic [7:0] REG_CTRL     = 8'd0;
    localparam logic [7:0] REG_INTERVAL = 8'd1;
    localparam logic [7:0] REG_LIMIT    = 8'd2;
    localparam logic [7:0] REG_STATUS   = 8'd3;
    localparam logic [7:0] REG_IRQ_EN   = 8'd4;

    localparam int CTRL_START     = 0;
    localparam int CTRL_HALT      = 1;
    localparam int CTRL_RESET_CMD = 2;
    localparam int CTRL_CLR_DONE  = 3;

    localparam int STAT_DONE   = 8;
    localparam int STAT_CFGERR = 9;
    localparam int STAT_IRQEN  = 10;

    function automatic logic [31:0] status_word(input logic [7:0] st, input logic done,
                                                input logic err, input logic en);
        return {21'd0, en, err, done, st};
    endfunction

endpackage

// File: rtl/counter_ctrl.sv
// Register-mapped control stage for the interval counter: host write/read
// channels, RESET/RUN/HALT FSM and the optional auto-halt on a count limit.
module counter_ctrl
    import counter_pkg::*;
#(
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wr_data,
    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_resp_valid,
    input  logic              rd_resp_ready,
    output logic [31:0]       rd_data,
    input  logic [31:0]       counter_value,
    output logic [7:0]        state,
    output logic [31:0]       interval,
    output logic              irq
);

    cnt_state_e  state_r, state_next_s;
    logic        first_run_r;
    logic [31:0] interval_r, limit_r, rd_data_r, rd_mux_s;
    logic        irq_en_r, done_r, cfg_err_r, wr_ready_r, rd_resp_valid_r, irq_r;
    logic        irq_en_next_s, done_next_s, cfg_err_next_s, irq_next_s;
    logic        wr_acc_s, rd_acc_s, ctrl_wr_s, cfg_wr_s, auto_cond_s, auto_halt_s;
    logic        cmd_rst_s, cmd_halt_s, cmd_start_s, cmd_clr_s;

    assign wr_acc_s     = wr_valid & wr_ready_r;
    assign rd_req_ready = ~rd_resp_valid_r | rd_resp_ready;
    assign rd_acc_s     = rd_req_valid & rd_req_ready;

    // Only the highest-priority command bit of a CTRL write takes effect.
    assign ctrl_wr_s   = wr_acc_s && (wr_addr == REG_CTRL[ADDR_W-1:0]);
    assign cmd_rst_s   = ctrl_wr_s & wr_data[CTRL_RESET_CMD];
    assign cmd_halt_s  = ctrl_wr_s & ~wr_data[CTRL_RESET_CMD] & wr_data[CTRL_HALT];
    assign cmd_start_s = ctrl_wr_s & ~wr_data[CTRL_RESET_CMD] & ~wr_data[CTRL_HALT]
                         & wr_data[CTRL_START];
    assign cmd_clr_s   = ctrl_wr_s & wr_data[CTRL_CLR_DONE];
    assign cfg_wr_s    = wr_acc_s && ((wr_addr == REG_INTERVAL[ADDR_W-1:0]) ||
                                      (wr_addr == REG_LIMIT[ADDR_W-1:0]));

    // counter_value is stale in the first RUN cycle after RESET, so skip that cycle.
    assign auto_cond_s = (state_r == ST_RUN) && !first_run_r && (limit_r != 32'd0) &&
                         (counter_value >= limit_r);

    // FSM state register, plus the first-RUN-cycle marker.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r     <= ST_RESET;
            first_run_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            first_run_r <= (state_r == ST_RESET) && (state_next_s == ST_RUN);
        end
    end

    // Next-state logic: CTRL transitions win over auto-halt.
    always_comb begin
        state_next_s = state_r;
        auto_halt_s  = 1'b0;
        case (state_r)
            ST_RESET, ST_RUN, ST_HALT: begin
                if (cmd_rst_s) begin
                    state_next_s = ST_RESET;
                end else if (cmd_halt_s && (state_r == ST_RUN)) begin
                    state_next_s = ST_HALT;
                end else if (cmd_start_s && (state_r != ST_RUN)) begin
                    state_next_s = ST_RUN;
                end else if (auto_cond_s) begin
                    state_next_s = ST_HALT;
                    auto_halt_s  = 1'b1;
                end else begin
                    state_next_s = state_r;
                end
            end
            default: state_next_s = ST_RESET;
        endcase
    end

    // Next values of the sticky flags and irq; an auto-halt set beats clear_done.
    always_comb begin
        irq_en_next_s  = irq_en_r;
        done_next_s    = done_r;
        cfg_err_next_s = cfg_err_r;
        if (wr_acc_s && (wr_addr == REG_IRQ_EN[ADDR_W-1:0])) begin
            irq_en_next_s = wr_data[0];
        end else begin
            irq_en_next_s = irq_en_r;
        end
        if (cmd_rst_s) begin
            done_next_s = 1'b0;
        end else if (auto_halt_s) begin
            done_next_s = 1'b1;
        end else if (cmd_clr_s) begin
            done_next_s = 1'b0;
        end else begin
            done_next_s = done_r;
        end
        if (cmd_rst_s) begin
            cfg_err_next_s = 1'b0;
        end else if (cfg_wr_s && (state_r == ST_RUN)) begin
            cfg_err_next_s = 1'b1;
        end else begin
            cfg_err_next_s = cfg_err_r;
        end
        irq_next_s = done_next_s & irq_en_next_s;
    end

    // Configuration registers, flags and the write-channel throttle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            interval_r <= 32'd0;
            limit_r    <= 32'd0;
            irq_en_r   <= 1'b0;
            done_r     <= 1'b0;
            cfg_err_r  <= 1'b0;
            irq_r      <= 1'b0;
            wr_ready_r <= 1'b1;
        end else begin
            if (wr_acc_s && (state_r != ST_RUN) && (wr_addr == REG_INTERVAL[ADDR_W-1:0])) begin
                interval_r <= wr_data;
            end
            if (wr_acc_s && (state_r != ST_RUN) && (wr_addr == REG_LIMIT[ADDR_W-1:0])) begin
                limit_r <= wr_data;
            end
            irq_en_r   <= irq_en_next_s;
            done_r     <= done_next_s;
            cfg_err_r  <= cfg_err_next_s;
            irq_r      <= irq_next_s;
            wr_ready_r <= ~wr_acc_s;
        end
    end

    // Read mux over the register map; CTRL and unmapped addresses read as zero.
    always_comb begin
        rd_mux_s = 32'd0;
        case (rd_addr)
            REG_INTERVAL[ADDR_W-1:0]: rd_mux_s = interval_r;
            REG_LIMIT[ADDR_W-1:0]:    rd_mux_s = limit_r;
            REG_STATUS[ADDR_W-1:0]:   rd_mux_s = status_word(state_r, done_r, cfg_err_r, irq_en_r);
            REG_IRQ_EN[ADDR_W-1:0]:   rd_mux_s = {31'd0, irq_en_r};
            default:                  rd_mux_s = 32'd0;
        endcase
    end

    // Read response register: captured on accept, held until the host takes it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_data_r       <= 32'd0;
            rd_resp_valid_r <= 1'b0;
        end else if (rd_acc_s) begin
            rd_data_r       <= rd_mux_s;
            rd_resp_valid_r <= 1'b1;
        end else if (rd_resp_ready) begin
            rd_resp_valid_r <= 1'b0;
        end
    end

    assign state         = state_r;
    assign interval      = interval_r;
    assign irq           = irq_r;
    assign wr_ready      = wr_ready_r;
    assign rd_resp_valid = rd_resp_valid_r;
    assign rd_data       = rd_data_r;

endmodule

// File: tb/tb_counter_ctrl.sv
// Self-checking bench for counter_ctrl: per-feature tasks plus a read-response
// scoreboard fed at request time and drained by a response monitor.
module tb_counter_ctrl;
    import counter_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        wr_valid, wr_ready;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rd_req_valid, rd_req_ready;
    logic [2:0]  rd_addr;
    logic        rd_resp_valid, rd_resp_ready;
    logic [31:0] rd_data;
    logic [31:0] counter_value;
    logic [7:0]  state;
    logic [31:0] interval;
    logic        irq;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;

    counter_ctrl #(.ADDR_W(3)) dut (
        .clk(clk), .resetn(resetn),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_addr(rd_addr),
        .rd_resp_valid(rd_resp_valid), .rd_resp_ready(rd_resp_ready), .rd_data(rd_data),
        .counter_value(counter_value), .state(state), .interval(interval), .irq(irq)
    );

    always #5 clk = ~clk;

    // Response monitor: a handshake completes at the next rising edge.
    always @(negedge clk) begin
        if (resetn && rd_resp_valid && rd_resp_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL rd_unexpected: got=%h with empty scoreboard", rd_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (rd_data !== mon_exp) begin
                    bad++;
                    $display("FAIL rd_data: got=%h want=%h", rd_data, mon_exp);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [31:0] d);
        int n = 0;
        while (!wr_ready && n < 10) begin
            step();
            n++;
        end
        total++;
        if (!wr_ready) begin
            bad++;
            $display("FAIL wr_ready_timeout: got=%b want=1", wr_ready);
        end
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        step();
        wr_valid = 1'b0;
        total++;
        if (wr_ready !== 1'b0) begin
            bad++;
            $display("FAIL wr_ready_drop: got=%b want=0", wr_ready);
        end
    endtask

    task automatic do_read(input logic [2:0] a, input logic [31:0] expv);
        int n = 0;
        exp_q.push_back(expv);
        rd_req_valid = 1'b1;
        rd_addr      = a;
        while (!rd_req_ready && n < 10) begin
            step();
            n++;
        end
        step();
        rd_req_valid = 1'b0;
        total++;
        if (rd_resp_valid !== 1'b1) begin
            bad++;
            $display("FAIL rd_latency: rd_resp_valid got=%b want=1", rd_resp_valid);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] got, input logic [7:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, got, want);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; wr_valid = 1'b0; wr_addr = 3'd0; wr_data = 32'd0;
        rd_req_valid = 1'b0; rd_addr = 3'd0; rd_resp_ready = 1'b1; counter_value = 32'd0;
        repeat (3) step();
        total++;
        if (state !== 8'd0 || interval !== 32'd0 || irq !== 1'b0 || wr_ready !== 1'b1 ||
            rd_resp_valid !== 1'b0 || rd_data !== 32'd0) begin
            bad++;
            $display("FAIL reset_vals: state=%h interval=%h irq=%b wr_ready=%b rv=%b rd=%h want 0,0,0,1,0,0",
                     state, interval, irq, wr_ready, rd_resp_valid, rd_data);
        end
        resetn = 1'b1;
        step();
        do_read(3'd3, 32'h0);
        do_write(3'd1, 32'd1);
        total++;
        if (interval !== 32'd1) begin
            bad++;
            $display("FAIL interval_one: got=%h want=1", interval);
        end
    endtask

    task automatic test_write_start();
        do_write(3'd1, 32'd5);
        step();
        total++;
        if (wr_ready !== 1'b1) begin
            bad++;
            $display("FAIL wr_ready_back: got=%b want=1", wr_ready);
        end
        total++;
        if (interval !== 32'd5) begin
            bad++;
            $display("FAIL interval_5: got=%h want=5", interval);
        end
        do_write(3'd0, 32'h1);
        check8("start_run", state, 8'd1);
        do_read(3'd1, 32'd5);
    endtask

    task automatic test_cfg_err();
        do_write(3'd1, 32'd9);
        total++;
        if (interval !== 32'd5) begin
            bad++;
            $display("FAIL interval_locked: got=%h want=5", interval);
        end
        do_read(3'd3, status_word(8'd1, 1'b0, 1'b1, 1'b0));
        do_write(3'd0, 32'h4);
        check8("reset_cmd", state, 8'd0);
        do_read(3'd3, 32'h0);
    endtask

    task automatic test_autohalt();
        do_write(3'd2, 32'd3);
        do_write(3'd4, 32'd1);
        counter_value = 32'd100;
        do_write(3'd0, 32'h1);
        check8("run_entry", state, 8'd1);
        step();
        check8("stale_suppressed", state, 8'd1);
        for (int v = 0; v < 3; v++) begin
            counter_value = v;
            step();
            check8("below_limit", state, 8'd1);
        end
        counter_value = 32'd3;
        step();
        check8("auto_halt", state, 8'd2);
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL irq_set: got=%b want=1", irq);
        end
        do_read(3'd3, status_word(8'd2, 1'b1, 1'b0, 1'b1));
        do_write(3'd0, 32'h8);
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL irq_clear: got=%b want=0", irq);
        end
    endtask

    task automatic test_read_stall();
        rd_resp_ready = 1'b0;
        exp_q.push_back(32'd5);
        rd_req_valid = 1'b1;
        rd_addr = 3'd1;
        step();
        exp_q.push_back(32'd3);
        rd_addr = 3'd2;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (rd_resp_valid !== 1'b1 || rd_data !== 32'd5 || rd_req_ready !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold: valid=%b data=%h req_ready=%b want 1,5,0",
                         rd_resp_valid, rd_data, rd_req_ready);
            end
            step();
        end
        rd_resp_ready = 1'b1;
        #1;
        total++;
        if (rd_req_ready !== 1'b1) begin
            bad++;
            $display("FAIL stall_release: req_ready got=%b want=1", rd_req_ready);
        end
        step();
        rd_req_valid = 1'b0;
        total++;
        if (rd_resp_valid !== 1'b1) begin
            bad++;
            $display("FAIL stall_next: rd_resp_valid got=%b want=1", rd_resp_valid);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [2:0]  addrs[6];
        logic [31:0] exps[6];
        addrs = '{3'd1, 3'd2, 3'd4, 3'd3, 3'd0, 3'd7};
        exps  = '{32'd5, 32'd3, 32'd1, status_word(8'd2, 1'b0, 1'b0, 1'b1), 32'd0, 32'd0};
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(exps[i]);
            rd_req_valid = 1'b1;
            rd_addr = addrs[i];
            total++;
            if (rd_req_ready !== 1'b1) begin
                bad++;
                $display("FAIL b2b_ready: idx=%0d got=%b want=1", i, rd_req_ready);
            end
            step();
        end
        rd_req_valid = 1'b0;
        step();
    endtask

    task automatic test_priority();
        counter_value = 32'd0;
        do_write(3'd0, 32'h1);
        check8("start_from_halt", state, 8'd1);
        do_write(3'd0, 32'h7);
        check8("reset_wins", state, 8'd0);
        do_write(3'd0, 32'h1);
        check8("restart", state, 8'd1);
        do_write(3'd0, 32'h2);
        check8("halt", state, 8'd2);
        do_write(3'd0, 32'h1);
        check8("start_halt_again", state, 8'd1);
        step();
        counter_value = 32'd10;
        do_write(3'd0, 32'h1);
        check8("noop_start_autohalt", state, 8'd2);
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL noop_irq: got=%b want=1", irq);
        end
    endtask

    initial begin
        test_reset();
        test_write_start();
        test_cfg_err();
        test_autohalt();
        test_read_stall();
        test_back_to_back();
        test_priority();
        for (int n = 0; n < 10 && exp_q.size() != 0; n++) step();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL rd_drain: pending=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
